// File: rtl/combo_code_recorder.sv
// Captures a NUM_STEPS-press btnL/btnC/btnR combination, replays it on the 7-segment display, then commits it to code.
// Optional macro RECORD_TIMEOUT_EN: abandons a recording after TIMEOUT_TICKS cycles without an accepted press.
module combo_code_recorder #(
  parameter int unsigned NUM_STEPS     = 5,
  parameter int unsigned STEP_TICKS    = 50000000,
  parameter int unsigned GAP_TICKS     = 5000000,
  parameter int unsigned TIMEOUT_TICKS = 500000000
) (
  input  logic                   CLOCK,
  input  logic                   RESETN,
  input  logic                   btnL,
  input  logic                   btnC,
  input  logic                   btnR,
  input  logic                   rec_start,
  output logic [2*NUM_STEPS-1:0] code,
  output logic                   code_valid,
  output logic                   busy,
  output logic [7:0]             seg,
  output logic [3:0]             an
);
  localparam int unsigned IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int unsigned CW    = 2 * NUM_STEPS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);
  localparam logic [7:0] GLYPH_L = 8'b11001111;
  localparam logic [7:0] GLYPH_C = 8'b10100111;
  localparam logic [7:0] GLYPH_R = 8'b10101111;
  localparam logic [7:0] BLANK   = 8'hFF;

  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_SHOW, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, ev_q, ev_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt_s;
  logic [CW-1:0]    shadow_q, shadow_d, code_q, code_d;
  logic [31:0]      tick_q, tick_d;
  logic             code_valid_q, code_valid_d, busy_q, busy_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic [1:0]       sym_s;
`ifdef RECORD_TIMEOUT_EN
  logic [31:0]      to_q, to_d;
`else
  logic             unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_TICKS == 32'd0);
`endif

  function automatic logic [7:0] glyph(input logic [1:0] sym);
    case (sym)
      2'b01:   glyph = GLYPH_L;
      2'b10:   glyph = GLYPH_C;
      2'b11:   glyph = GLYPH_R;
      default: glyph = BLANK;
    endcase
  endfunction

  function automatic logic [3:0] digit(input logic [IDX_W-1:0] k);
    logic [1:0] k2;
    k2 = 2'(k);
    digit = 4'hF;
    digit[k2] = 1'b0;
  endfunction

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign busy       = busy_q;
  assign seg        = seg_q;
  assign an         = an_q;

  // Next-state logic: button sync/edge path plus the record/playback FSM
  always_comb begin
    sync1_d      = {btnR, btnC, btnL};
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    ev_d         = sync2_q & ~prev_q;
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    code_d       = code_q;
    code_valid_d = code_valid_q;
    busy_d       = busy_q;
    seg_d        = seg_q;
    an_d         = an_q;
    tick_d       = 32'd0;
    idx_nxt_s    = idx_q + IDX_W'(1);
`ifdef RECORD_TIMEOUT_EN
    to_d         = 32'd0;
`endif
    // L beats C beats R when events coincide
    if (ev_q[0])      sym_s = 2'b01;
    else if (ev_q[1]) sym_s = 2'b10;
    else if (ev_q[2]) sym_s = 2'b11;
    else              sym_s = 2'b00;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        seg_d  = BLANK;
        an_d   = 4'hF;
        if (rec_start) begin
          state_d      = S_RECORD;
          idx_d        = '0;
          shadow_d     = '0;
          code_valid_d = 1'b0;
          busy_d       = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RECORD: begin
        busy_d = 1'b1;
        if (rec_start) begin
          idx_d    = '0;
          shadow_d = '0;
          seg_d    = BLANK;
          an_d     = 4'hF;
        end else if (sym_s != 2'b00) begin
          shadow_d[{idx_q, 1'b0} +: 2] = sym_s;
          if (idx_q == LAST_IDX) begin
            state_d = S_SHOW;
            idx_d   = '0;
            seg_d   = glyph(shadow_d[1:0]);
            an_d    = digit('0);
          end else begin
            idx_d = idx_nxt_s;
            seg_d = glyph(sym_s);
            an_d  = digit(idx_q);
          end
`ifdef RECORD_TIMEOUT_EN
        end else if (to_q >= 32'(TIMEOUT_TICKS - 1)) begin
          state_d  = S_IDLE;
          idx_d    = '0;
          shadow_d = '0;
          busy_d   = 1'b0;
          seg_d    = BLANK;
          an_d     = 4'hF;
        end else begin
          to_d = to_q + 32'd1;
        end
`else
        end else begin
          state_d = S_RECORD;
        end
`endif
      end
      S_SHOW: begin
        if (tick_q == 32'(STEP_TICKS - 1)) begin
          state_d = S_GAP;
          seg_d   = BLANK;
          an_d    = 4'hF;
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
      S_GAP: begin
        if (tick_q != 32'(GAP_TICKS - 1)) begin
          tick_d = tick_q + 32'd1;
        end else if (idx_q == LAST_IDX) begin
          state_d      = S_IDLE;
          idx_d        = '0;
          code_d       = shadow_q;
          code_valid_d = 1'b1;
          busy_d       = 1'b0;
        end else begin
          state_d = S_SHOW;
          idx_d   = idx_nxt_s;
          seg_d   = glyph(shadow_q[{idx_nxt_s, 1'b0} +: 2]);
          an_d    = digit(idx_nxt_s);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= S_IDLE;
      sync1_q      <= 3'b000;
      sync2_q      <= 3'b000;
      prev_q       <= 3'b000;
      ev_q         <= 3'b000;
      idx_q        <= '0;
      shadow_q     <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      seg_q        <= BLANK;
      an_q         <= 4'hF;
      tick_q       <= 32'd0;
`ifdef RECORD_TIMEOUT_EN
      to_q         <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      ev_q         <= ev_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      busy_q       <= busy_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
`ifdef RECORD_TIMEOUT_EN
      to_q         <= to_d;
`endif
    end
  end
endmodule

// File: tb/tb_combo_code_recorder.sv
// Self-checking bench for combo_code_recorder using STEP_TICKS=4, GAP_TICKS=2, TIMEOUT_TICKS=20.
module tb_combo_code_recorder;
  localparam logic [7:0] GL = 8'b11001111;
  localparam logic [7:0] GC = 8'b10100111;
  localparam logic [7:0] GR = 8'b10101111;
  localparam logic [2:0] ML = 3'b001;
  localparam logic [2:0] MC = 3'b010;
  localparam logic [2:0] MR = 3'b100;

  logic       CLOCK = 1'b0;
  logic       RESETN = 1'b0;
  logic       btnL = 1'b0, btnC = 1'b0, btnR = 1'b0, rec_start = 1'b0;
  logic [9:0] code;
  logic       code_valid, busy;
  logic [7:0] seg;
  logic [3:0] an;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [14:0] masks;
    logic [9:0]  exp_code;
  } vec_t;
  typedef struct packed {
    logic       busy;
    logic [7:0] seg;
    logic [3:0] an;
  } disp_t;

  vec_t        vec[4];
  logic [9:0]  code_q_exp[$];
  disp_t       disp_q[$];
  logic [9:0]  last_code;

  combo_code_recorder #(
    .NUM_STEPS(5), .STEP_TICKS(4), .GAP_TICKS(2), .TIMEOUT_TICKS(20)
  ) dut (
    .CLOCK(CLOCK), .RESETN(RESETN), .btnL(btnL), .btnC(btnC), .btnR(btnR),
    .rec_start(rec_start), .code(code), .code_valid(code_valid), .busy(busy),
    .seg(seg), .an(an)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [2:0] m);
    @(negedge CLOCK);
    {btnR, btnC, btnL} = m;
    repeat (2) @(negedge CLOCK);
    {btnR, btnC, btnL} = 3'b000;
    repeat (3) @(negedge CLOCK);
  endtask

  task automatic start_rec();
    @(negedge CLOCK);
    rec_start = 1'b1;
    @(negedge CLOCK);
    rec_start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit && busy !== 1'b0; i++) @(negedge CLOCK);
    if (busy !== 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle: busy still %b after %0d cycles", busy, limit);
    end
  endtask

  task automatic record_and_check(input logic [14:0] masks, input logic [9:0] exp, input string name);
    logic [9:0] e;
    start_rec();
    check({name, "_busy_rec"}, {31'd0, busy}, 32'd1);
    check({name, "_valid_drop"}, {31'd0, code_valid}, 32'd0);
    check({name, "_code_held"}, {22'd0, code}, {22'd0, last_code});
    code_q_exp.push_back(exp);
    for (int k = 0; k < 5; k++) press(masks[3*k +: 3]);
    wait_idle(80);
    e = code_q_exp.pop_front();
    check({name, "_code"}, {22'd0, code}, {22'd0, e});
    check({name, "_valid"}, {31'd0, code_valid}, 32'd1);
    last_code = e;
  endtask

  initial begin
    logic found;
    disp_t d;
    logic [7:0] gl[5];
    logic [3:0] anx[5];

    vec[0] = '{masks: {ML, MC, ML, MR, ML}, exp_code: 10'b0110011101};
    vec[1] = '{masks: {MC, MC, MC, MC, MC}, exp_code: 10'b1010101010};
    vec[2] = '{masks: {ML, MR, MC, MR, ML | MR}, exp_code: 10'b0111101101};
    vec[3] = '{masks: {MC, ML | MC | MR, MR, MR, MC | MR}, exp_code: 10'b1001111110};
    last_code = 10'd0;

    // Reset and idle behaviour
    repeat (3) @(negedge CLOCK);
    check("rst_seg", {24'd0, seg}, 32'hFF);
    RESETN = 1'b1;
    repeat (10) @(negedge CLOCK);
    check("idle_seg", {24'd0, seg}, 32'hFF);
    check("idle_an", {28'd0, an}, 32'hF);
    check("idle_code", {22'd0, code}, 32'd0);
    check("idle_valid", {31'd0, code_valid}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    press(ML);
    press(MR);
    check("idle_press_seg", {24'd0, seg}, 32'hFF);
    check("idle_press_an", {28'd0, an}, 32'hF);
    check("idle_press_busy", {31'd0, busy}, 32'd0);
    check("idle_press_code", {22'd0, code}, 32'd0);

    // Table-driven recordings
    for (int i = 0; i < 4; i++) record_and_check(vec[i].masks, vec[i].exp_code, $sformatf("vec%0d", i));

    // Playback timing of L,R,L,C,L with in-record display checks
    start_rec();
    press(ML);
    check("rec_disp0_seg", {24'd0, seg}, {24'd0, GL});
    check("rec_disp0_an", {28'd0, an}, 32'hE);
    press(MR);
    check("rec_disp1_seg", {24'd0, seg}, {24'd0, GR});
    check("rec_disp1_an", {28'd0, an}, 32'hD);
    press(ML);
    press(MC);
    check("rec_disp3_seg", {24'd0, seg}, {24'd0, GC});
    check("rec_disp3_an", {28'd0, an}, 32'h7);
    gl  = '{GL, GR, GL, GC, GL};
    anx = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    for (int s = 0; s < 5; s++) begin
      for (int t = 0; t < 4; t++) disp_q.push_back('{busy: 1'b1, seg: gl[s], an: anx[s]});
      for (int t = 0; t < 2; t++) disp_q.push_back('{busy: 1'b1, seg: 8'hFF, an: 4'hF});
    end
    btnL = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLOCK);
      if (seg == GL && an == 4'b1110) found = 1'b1;
    end
    btnL = 1'b0;
    check("play_start_found", {31'd0, found}, 32'd1);
    for (int i = 0; disp_q.size() > 0; i++) begin
      if (i > 0) @(negedge CLOCK);
      d = disp_q.pop_front();
      check($sformatf("play_cyc%0d", i), {19'd0, busy, seg, an}, {19'd0, d.busy, d.seg, d.an});
      check($sformatf("play_valid%0d", i), {31'd0, code_valid}, 32'd0);
    end
    @(negedge CLOCK);
    check("play_end_busy", {31'd0, busy}, 32'd0);
    check("play_end_valid", {31'd0, code_valid}, 32'd1);
    check("play_end_code", {22'd0, code}, 32'h19D);
    check("play_end_seg", {24'd0, seg}, 32'hFF);
    last_code = 10'b0110011101;

    // Restart in the middle of a recording
    start_rec();
    code_q_exp.push_back(10'b1010101010);
    press(ML);
    press(ML);
    press(MR);
    check("mid_seg_before", {24'd0, seg}, {24'd0, GR});
    check("mid_an_before", {28'd0, an}, 32'hB);
    start_rec();
    check("mid_restart_seg", {24'd0, seg}, 32'hFF);
    check("mid_restart_an", {28'd0, an}, 32'hF);
    check("mid_restart_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 5; k++) press(MC);
    wait_idle(80);
    check("mid_code", {22'd0, code}, {22'd0, code_q_exp.pop_front()});
    check("mid_valid", {31'd0, code_valid}, 32'd1);
    last_code = 10'b1010101010;

`ifdef RECORD_TIMEOUT_EN
    // Abandoned recording times out and keeps the prior code
    start_rec();
    press(ML);
    press(MR);
    wait_idle(60);
    check("to_code", {22'd0, code}, {22'd0, last_code});
    check("to_valid", {31'd0, code_valid}, 32'd0);
    check("to_seg", {24'd0, seg}, 32'hFF);
`endif

    // Reset during playback step 2
    start_rec();
    for (int k = 0; k < 5; k++) press(MR);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (an == 4'b1011 && seg == GR) found = 1'b1;
      else @(negedge CLOCK);
    end
    check("rst_play_found", {31'd0, found}, 32'd1);
    RESETN = 1'b0;
    #1;
    check("rst_play_seg", {24'd0, seg}, 32'hFF);
    check("rst_play_an", {28'd0, an}, 32'hF);
    check("rst_play_busy", {31'd0, busy}, 32'd0);
    check("rst_play_code", {22'd0, code}, 32'd0);
    check("rst_play_valid", {31'd0, code_valid}, 32'd0);
    @(negedge CLOCK);
    RESETN = 1'b1;
    repeat (40) @(negedge CLOCK);
    check("post_rst_code", {22'd0, code}, 32'd0);
    check("post_rst_valid", {31'd0, code_valid}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
